mips_alu_seq: RTL and testbench
===============================

Name: mips_alu_seq

Overview:
Parametrised successor to the single-cycle MIPSALU, for the next-generation datapath. It keeps the existing ALUCtl encodings and adds XOR, shifts and unsigned compare. It also adds iterative multiply/divide with HI/LO registers. Operations are issued through a valid/ready handshake, so the control FSM can stall the datapath while a multi-cycle op completes.

Parameters:
WIDTH, 32, operand/result width; must be a power of 2 and at least 8.
SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
CLK  in  1  clock; all state changes on posedge.
RESET  in  1  synchronous reset, active-high.
in_valid  in  1  operation request.
in_ready  out  1  block can accept a request this cycle.
ALUCtl  in  4  operation code.
A  in  WIDTH  operand rs.
B  in  WIDTH  operand rt.
shamt  in  SHW  shift amount.
out_valid  out  1  result registers hold a valid result.
out_ready  in  1  consumer takes the result this cycle.
ALUOut  out  WIDTH  registered result.
Zero  out  1  registered (ALUOut == 0).
Overflow  out  1  registered signed overflow / DIV overflow.
DivZero  out  1  registered divide-by-zero flag.
HI  out  WIDTH  HI register.
LO  out  WIDTH  LO register.
busy  out  1  multiply/divide in progress.

Behaviour:
- Reset (sync, RESET=1 at posedge):
  - state=IDLE.
  - out_valid, ALUOut, Zero, Overflow, DivZero, HI, LO, busy all 0.
  - Any in-flight mul/div is aborted with no HI/LO update. Reset has priority over every other event in the same cycle.
- Acceptance and handshake:
  - A request is accepted at a posedge when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back issue with zero bubbles.
  - out_valid clears on out_ready unless a new result is written in the same edge.
  - ALUOut, Zero, Overflow and DivZero are held stable while out_valid && !out_ready.
- Single-cycle ops:
  - Result is registered at the accepting edge, so out_valid=1 on the next cycle (latency 1).
  - Overflow=0 and DivZero=0 unless stated otherwise below.
  - Operations by ALUCtl:
    - 0 AND: A&B.
    - 1 OR: A|B.
    - 2 ADD: A+B, wraps; Overflow = signed overflow.
    - 3 XOR: A^B.
    - 4 SLL: B<<shamt.
    - 5 SRL: B>>shamt (logical).
    - 6 SUB: A-B, wraps; Overflow = signed overflow.
    - 7 SLT: signed A<B gives 1, else 0.
    - 8 SLTU: unsigned A<B gives 1, else 0.
    - 9 SRA: B>>>shamt (arithmetic).
    - 12 NOR: ~(A|B).
    - 15 (reserved): ALUOut=0, Zero=1.
- Multi-cycle ops:
  - Codes: 10 MULT (signed), 11 MULTU, 13 DIV (signed), 14 DIVU.
  - State machine: IDLE -> LOAD -> ITER (WIDTH cycles) -> FIX -> IDLE.
    - LOAD latches operand magnitudes and result signs.
    - ITER performs one shift-add (multiply) or one restoring subtract (divide) per cycle using a 5-bit-independent iteration counter.
    - FIX applies sign correction and writes HI/LO/ALUOut.
  - busy=1 from the accepting edge until the FIX edge. in_ready=0 while busy.
  - out_valid asserts exactly WIDTH+2 posedges after the accepting edge: 34 for WIDTH=32.
  - MULT/MULTU: {HI,LO} = full 2*WIDTH product; ALUOut=LO; Zero=(LO==0).
  - DIV/DIVU:
    - LO=quotient, HI=remainder, ALUOut=LO.
    - Quotient truncates toward zero; remainder takes the sign of A.
  - Divide by zero (B==0):
    - Still takes the full latency.
    - LO=all ones, HI=A, DivZero=1.
  - Signed DIV of most-negative / -1:
    - LO=most-negative, HI=0, Overflow=1.
  - HI and LO change only at a mul/div FIX edge or at reset. Single-cycle ops never modify them.
- Illegal input: in_valid asserted while in_ready=0 is ignored. No state change occurs and no error is flagged.

Test Plan:
1. Reset, then ADD A=0x7FFFFFFF, B=1 -> next cycle out_valid=1, ALUOut=0x80000000, Overflow=1, Zero=0. Then SUB A=5, B=5 -> ALUOut=0, Zero=1, Overflow=0.
2. SLT A=0xFFFFFFFF, B=1 -> ALUOut=1. SLTU with the same operands -> ALUOut=0. SRA B=0x80000000, shamt=4 -> 0xF8000000. SRL with the same operands -> 0x08000000.
3. MULT A=0xFFFFFFFE (-2), B=3 -> busy for 34 cycles, in_ready=0 throughout, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
4. DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7, DivZero=1. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0, Overflow=1.
5. Back-pressure: issue AND, hold out_ready=0 for 5 cycles -> in_ready=0 and ALUOut stable. Pulse out_ready with in_valid high -> next op accepted in the same cycle, with no bubble.
6. Reset mid-operation: start MULT, assert RESET at iteration 10 -> next cycle busy=0, HI=LO=0, out_valid=0, in_ready=1. A subsequent ADD completes normally.

Source files
------------

// File: rtl/mips_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mips_alu_seq
// Brief   : Handshaked MIPS ALU with single-cycle ops and iterative mul/div
//           producing HI/LO.
// Revision: 1.0  initial release
// ============================================================================
module mips_alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUCtl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUOut,
   output logic             Zero,
   output logic             Overflow,
   output logic             DivZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] c_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [3:0]       c_op_mult  = 4'd10;
   localparam logic [3:0]       c_op_multu = 4'd11;
   localparam logic [3:0]       c_op_div   = 4'd13;
   localparam logic [3:0]       c_op_divu  = 4'd14;

   state_t           state_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, mag_q, acc_hi_q, acc_lo_q;
   logic [SHW-1:0]   cnt_q;
   logic             neg_q, neg_rem_q;
   logic             out_valid_q, zero_q, ovf_q, divzero_q, busy_q;
   logic [WIDTH-1:0] alu_out_q, hi_q, lo_q;

   logic               is_multi_d, op_div_d, op_signed_d, sc_ovf_d, rem_ge_d;
   logic [WIDTH-1:0]   sum_d, diff_d, sc_res_d, abs_a_d, abs_b_d, rem_sub_d;
   logic [WIDTH-1:0]   quot_d, rem_d;
   logic [WIDTH:0]     mul_sum_d, rem_sh_d;
   logic [2*WIDTH-1:0] prod_d;

   assign is_multi_d  = (ALUCtl == c_op_mult) || (ALUCtl == c_op_multu) ||
                        (ALUCtl == c_op_div)  || (ALUCtl == c_op_divu);
   assign op_div_d    = (op_q == c_op_div) || (op_q == c_op_divu);
   assign op_signed_d = (op_q == c_op_mult) || (op_q == c_op_div);

   assign sum_d  = A + B;
   assign diff_d = A - B;

   always_comb begin
      sc_res_d = '0;
      sc_ovf_d = 1'b0;
      case (ALUCtl)
         4'd0:  sc_res_d = A & B;
         4'd1:  sc_res_d = A | B;
         4'd2: begin
            sc_res_d = sum_d;
            sc_ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum_d[WIDTH-1] != A[WIDTH-1]);
         end
         4'd3:  sc_res_d = A ^ B;
         4'd4:  sc_res_d = B << shamt;
         4'd5:  sc_res_d = B >> shamt;
         4'd6: begin
            sc_res_d = diff_d;
            sc_ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff_d[WIDTH-1] != A[WIDTH-1]);
         end
         4'd7:  sc_res_d = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         4'd8:  sc_res_d = {{(WIDTH-1){1'b0}}, A < B};
         4'd9:  sc_res_d = $unsigned($signed(B) >>> shamt);
         4'd12: sc_res_d = ~(A | B);
         default: sc_res_d = '0;
      endcase
   end

   // Iteration datapath: unsigned magnitudes, sign restored in FIX.
   assign abs_a_d   = (op_signed_d && a_q[WIDTH-1]) ? -a_q : a_q;
   assign abs_b_d   = (op_signed_d && b_q[WIDTH-1]) ? -b_q : b_q;
   assign mul_sum_d = {1'b0, acc_hi_q} + ({(WIDTH+1){acc_lo_q[0]}} & {1'b0, mag_q});
   assign rem_sh_d  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign rem_ge_d  = rem_sh_d >= {1'b0, mag_q};
   assign rem_sub_d = rem_sh_d[WIDTH-1:0] - mag_q;
   assign prod_d    = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign quot_d    = neg_q ? -acc_lo_q : acc_lo_q;
   assign rem_d     = neg_rem_q ? -acc_hi_q : acc_hi_q;

   assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mag_q       <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         neg_rem_q   <= 1'b0;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         divzero_q   <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         busy_q      <= 1'b0;
      end else begin
         if (out_valid_q && out_ready)
            out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  if (is_multi_d) begin
                     op_q    <= ALUCtl;
                     a_q     <= A;
                     b_q     <= B;
                     busy_q  <= 1'b1;
                     state_q <= S_LOAD;
                  end else begin
                     alu_out_q   <= sc_res_d;
                     zero_q      <= (sc_res_d == '0);
                     ovf_q       <= sc_ovf_d;
                     divzero_q   <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               acc_lo_q  <= op_div_d ? abs_a_d : abs_b_d;
               mag_q     <= op_div_d ? abs_b_d : abs_a_d;
               neg_q     <= op_signed_d && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               neg_rem_q <= op_signed_d && a_q[WIDTH-1];
               acc_hi_q  <= '0;
               cnt_q     <= '1;
               state_q   <= S_ITER;
            end
            S_ITER: begin
               if (op_div_d) begin
                  acc_hi_q <= rem_ge_d ? rem_sub_d : rem_sh_d[WIDTH-1:0];
                  acc_lo_q <= {acc_lo_q[WIDTH-2:0], rem_ge_d};
               end else begin
                  acc_hi_q <= mul_sum_d[WIDTH:1];
                  acc_lo_q <= {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
               end
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == '0)
                  state_q <= S_FIX;
            end
            S_FIX: begin
               ovf_q     <= 1'b0;
               divzero_q <= 1'b0;
               if (!op_div_d) begin
                  {hi_q, lo_q} <= prod_d;
                  alu_out_q    <= prod_d[WIDTH-1:0];
                  zero_q       <= (prod_d[WIDTH-1:0] == '0);
               end else if (mag_q == '0) begin
                  hi_q      <= a_q;
                  lo_q      <= '1;
                  alu_out_q <= '1;
                  zero_q    <= 1'b0;
                  divzero_q <= 1'b1;
               end else begin
                  hi_q      <= rem_d;
                  lo_q      <= quot_d;
                  alu_out_q <= quot_d;
                  zero_q    <= (quot_d == '0);
                  ovf_q     <= op_signed_d && (a_q == c_min_neg) && (b_q == '1);
               end
               out_valid_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign ALUOut    = alu_out_q;
   assign Zero      = zero_q;
   assign Overflow  = ovf_q;
   assign DivZero   = divzero_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mips_alu_seq
// Brief   : Scoreboard bench for mips_alu_seq against an arithmetic model.
// Revision: 1.0  initial release
// ============================================================================
module tb_mips_alu_seq;
   localparam longint c_max_s = 64'sd2147483647;
   localparam longint c_min_s = -64'sd2147483648;

   logic        CLK = 1'b0;
   logic        RESET, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  ALUCtl;
   logic [31:0] A, B, ALUOut, HI, LO;
   logic [4:0]  shamt;
   logic        Zero, Overflow, DivZero, busy;

   always #5 CLK = ~CLK;

   mips_alu_seq #(.WIDTH(32), .SHW(5)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .ALUCtl(ALUCtl), .A(A), .B(B), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready), .ALUOut(ALUOut),
      .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero),
      .HI(HI), .LO(LO), .busy(busy)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] res;
      logic        zero, ovf, dz;
      logic [31:0] hi, lo;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        m_e;
   logic [31:0] ref_hi = '0, ref_lo = '0;
   int          n_checks = 0, n_errors = 0;
   bit          rand_bp = 1'b0;

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh);
      exp_t        e;
      longint      sa, sb, t;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.op = op; e.res = '0; e.ovf = 1'b0; e.dz = 1'b0;
      case (op)
         4'd0:  e.res = a & b;
         4'd1:  e.res = a | b;
         4'd2:  begin t = sa + sb; e.res = t[31:0]; e.ovf = (t > c_max_s) || (t < c_min_s); end
         4'd3:  e.res = a ^ b;
         4'd4:  e.res = b << sh;
         4'd5:  e.res = b >> sh;
         4'd6:  begin t = sa - sb; e.res = t[31:0]; e.ovf = (t > c_max_s) || (t < c_min_s); end
         4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd8:  e.res = (a < b) ? 32'd1 : 32'd0;
         4'd9:  begin t = sb >>> sh; e.res = t[31:0]; end
         4'd10: begin t = sa * sb; p = t; {ref_hi, ref_lo} = p; end
         4'd11: begin p = {32'd0, a} * {32'd0, b}; {ref_hi, ref_lo} = p; end
         4'd12: e.res = ~(a | b);
         4'd13, 4'd14: begin
            if (b == 32'd0) begin
               ref_lo = 32'hFFFF_FFFF; ref_hi = a; e.dz = 1'b1;
            end else if (op == 4'd13 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               ref_lo = 32'h8000_0000; ref_hi = 32'd0; e.ovf = 1'b1;
            end else if (op == 4'd13) begin
               t = sa / sb; ref_lo = t[31:0];
               t = sa % sb; ref_hi = t[31:0];
            end else begin
               ref_lo = a / b; ref_hi = a % b;
            end
         end
         default: e.res = '0;
      endcase
      if (op == 4'd10 || op == 4'd11 || op == 4'd13 || op == 4'd14)
         e.res = ref_lo;
      e.zero = (e.res == 32'd0);
      e.hi = ref_hi;
      e.lo = ref_lo;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      int n;
      n = 0;
      ALUCtl = op; A = a; B = b; shamt = sh; in_valid = 1'b1;
      forever begin
         @(negedge CLK);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            n_checks++; n_errors++;
            $display("FAIL issue_timeout: op=%0d in_ready stayed %b, expected 1", op, in_ready);
            in_valid = 1'b0;
            return;
         end
         @(posedge CLK); #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
      sb_q.push_back(model(op, a, b, sh));
      @(posedge CLK); #1;
      in_valid = 1'b0;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 15));
         5: return -32'($urandom_range(1, 9));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every consumed result is compared with the oldest expectation.
   initial begin
      forever begin
         @(negedge CLK);
         if (!RESET && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_result: got ALUOut=%h with no pending operation", ALUOut);
            end else begin
               m_e = sb_q.pop_front();
               if (ALUOut !== m_e.res || Zero !== m_e.zero || Overflow !== m_e.ovf ||
                   DivZero !== m_e.dz || HI !== m_e.hi || LO !== m_e.lo) begin
                  n_errors++;
                  $display("FAIL result op=%0d: got out=%h z=%b ov=%b dz=%b hi=%h lo=%h, expected out=%h z=%b ov=%b dz=%b hi=%h lo=%h",
                           m_e.op, ALUOut, Zero, Overflow, DivZero, HI, LO,
                           m_e.res, m_e.zero, m_e.ovf, m_e.dz, m_e.hi, m_e.lo);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, viol, n;
      logic [31:0] and_a, and_b, x_a, x_b, ra, rb;
      logic [3:0]  rop;
      RESET = 1'b1; in_valid = 1'b0; ALUCtl = '0; A = '0; B = '0; shamt = '0; out_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      check("reset_flags", {59'd0, out_valid, busy, Zero, Overflow, DivZero}, 64'd0);
      check("reset_hilo", {HI, LO}, 64'd0);
      check("reset_aluout", {32'd0, ALUOut}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);

      issue(4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0);
      check("add_ovf_direct", {31'd0, ALUOut, Overflow}, {31'd0, 32'h8000_0000, 1'b1});
      issue(4'd6, 32'd5, 32'd5, 5'd0);
      issue(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);
      issue(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0);
      issue(4'd9, 32'd0, 32'h8000_0000, 5'd4);
      check("sra_direct", {32'd0, ALUOut}, {32'd0, 32'hF800_0000});
      issue(4'd5, 32'd0, 32'h8000_0000, 5'd4);

      issue(4'd10, 32'hFFFF_FFFE, 32'd3, 5'd0);
      lat = 0; viol = 0;
      if (!busy || in_ready) viol++;
      for (int k = 1; k <= 60; k++) begin
         @(posedge CLK); #1;
         if (out_valid) begin lat = k; break; end
         if (!busy || in_ready) viol++;
      end
      check("mult_latency", 64'(lat), 64'd34);
      check("mult_busy_window", 64'(viol), 64'd0);
      check("mult_busy_clear", {63'd0, busy}, 64'd0);
      check("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);

      issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      issue(4'd13, -32'd7, 32'd2, 5'd0);
      issue(4'd14, 32'd7, 32'd0, 5'd0);
      issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);

      // Back-pressure: stall a result while the next request waits.
      and_a = 32'hF0F0_1234; and_b = 32'h0FF0_FF00; x_a = 32'h1357_9BDF; x_b = 32'h0F0F_F0F0;
      issue(4'd0, and_a, and_b, 5'd0);
      out_ready = 1'b0;
      ALUCtl = 4'd3; A = x_a; B = x_b; in_valid = 1'b1;
      viol = 0;
      repeat (5) begin
         @(posedge CLK); #1;
         if (!out_valid || in_ready || busy || ALUOut !== (and_a & and_b)) viol++;
      end
      check("bp_stall_stable", 64'(viol), 64'd0);
      out_ready = 1'b1;
      @(negedge CLK);
      check("bp_in_ready", {63'd0, in_ready}, 64'd1);
      sb_q.push_back(model(4'd3, x_a, x_b, 5'd0));
      @(posedge CLK); #1;
      in_valid = 1'b0;
      check("bp_no_bubble", {31'd0, out_valid, ALUOut}, {31'd0, 1'b1, x_a ^ x_b});

      // Reset during the tenth multiply iteration.
      issue(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
      repeat (10) @(posedge CLK);
      #1 RESET = 1'b1;
      sb_q.delete(); ref_hi = '0; ref_lo = '0;
      @(posedge CLK); #1 RESET = 1'b0;
      check("rst_mid_flags", {61'd0, busy, out_valid, in_ready}, 64'd1);
      check("rst_mid_hilo", {HI, LO}, 64'd0);
      issue(4'd2, 32'd100, 32'd23, 5'd0);

      rand_bp = 1'b1;
      for (int i = 0; i < 150; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra = pick();
         rb = pick();
         issue(rop, ra, rb, 5'($urandom_range(0, 31)));
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;

      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge CLK); n++;
      end
      @(posedge CLK); #1;
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
